// File: rtl/stream_idct_pixel_pack_pkg.sv
// Shared constants for the IDCT pixel packer.
//   PIXEL_WIDTH          width of one output pixel
//   PIXELS_PER_BEAT      pixels carried by one 64-bit output beat
//   COEFS_PER_BEAT       coefficients carried by one 64-bit input beat
//   COEF_SLOT_WIDTH      bit slot reserved for each coefficient in an input beat
//   DEFAULT_DESCALE      default arithmetic right shift per coefficient
//   DEFAULT_LEVEL_SHIFT  default offset added after descale
// pair_mask() returns the two strobe bits owned by an input beat index.
package stream_idct_pkg;

  localparam int PIXEL_WIDTH         = 8;
  localparam int PIXELS_PER_BEAT     = 8;
  localparam int COEFS_PER_BEAT      = 2;
  localparam int COEF_SLOT_WIDTH     = 32;
  localparam int STREAM_DATA_WIDTH   = 64;
  localparam int DEFAULT_DESCALE     = 3;
  localparam int DEFAULT_LEVEL_SHIFT = 128;

  typedef logic [1:0] beat_idx_t;

  function automatic logic [PIXELS_PER_BEAT-1:0] pair_mask(input beat_idx_t idx);
    return PIXELS_PER_BEAT'(2'b11) << {idx, 1'b0};
  endfunction

endpackage

// File: rtl/stream_idct_pixel_pack_if.sv
// AXI-stream style channel used on both sides of the pixel packer.
// Handshake: a beat transfers on a rising clock edge where t_valid and
// t_ready are both 1; once t_valid is raised the master keeps it and all
// payload fields stable until that transfer happens.
//   t_valid/t_ready  handshake
//   t_data           payload, t_strb/t_keep one bit per byte
//   t_last           final beat of a block
//   t_id/t_dest/t_user  routing sidebands (unused by the packer, driven 0)
// Modports: master drives payload and valid, slave drives ready.
interface nasti_stream_channel
  import stream_idct_pkg::*;
#(
  parameter int DATA_WIDTH = STREAM_DATA_WIDTH,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1
);

  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [ID_WIDTH-1:0]     t_id;
  logic [DEST_WIDTH-1:0]   t_dest;
  logic [USER_WIDTH-1:0]   t_user;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    output t_ready
  );

endinterface

// File: rtl/stream_idct_pixel_pack_sat.sv
// idct_pixel_sat: converts one signed IDCT coefficient into an unsigned
// 8-bit pixel: descale by arithmetic shift, add level shift, clamp 0..255.
// Optional macro STREAM_IDCT_PIXEL_ROUND_EN adds 2^(DESCALE-1) before the
// shift (round half up); without it the shift truncates toward -inf.
//   coef   signed coefficient, COEF_WIDTH bits
//   pixel  saturated pixel
// Purely combinational.
module idct_pixel_sat
  import stream_idct_pkg::*;
#(
  parameter int COEF_WIDTH  = 32,
  parameter int DESCALE     = DEFAULT_DESCALE,
  parameter int LEVEL_SHIFT = DEFAULT_LEVEL_SHIFT
) (
  input  logic [COEF_WIDTH-1:0]  coef,
  output logic [PIXEL_WIDTH-1:0] pixel
);

  // Two guard bits: the rounding add on the most positive coefficient and
  // the level shift on the most negative one both stay in range.
  localparam int W2 = COEF_WIDTH + 2;

  localparam logic signed [W2-1:0] LVL     = W2'(LEVEL_SHIFT);
  localparam logic signed [W2-1:0] PIX_MAX = W2'((1 << PIXEL_WIDTH) - 1);
`ifdef STREAM_IDCT_PIXEL_ROUND_EN
  localparam logic signed [W2-1:0] RND = W2'(1) << (DESCALE - 1);
`else
  localparam logic signed [W2-1:0] RND = '0;
`endif

  logic signed [W2-1:0] ext;
  logic signed [W2-1:0] biased;
  logic signed [W2-1:0] shifted;
  logic signed [W2-1:0] level;

  always_comb begin
    ext     = {{2{coef[COEF_WIDTH-1]}}, coef};
    biased  = ext + RND;
    shifted = biased >>> DESCALE;
    level   = shifted + LVL;
    if (level[W2-1]) begin
      pixel = '0;
    end else if (level > PIX_MAX) begin
      pixel = '1;
    end else begin
      pixel = level[PIXEL_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/stream_idct_pixel_pack.sv
// stream_idct_pixel_pack: turns a stream of IDCT coefficient pairs into a
// stream of packed 8-bit pixels. Four input beats fill one output beat;
// t_last on an input beat flushes a partial output beat early, with the
// unused bytes zero and their strobes clear.
//   aclk, aresetn  clock, asynchronous active-low reset
//   in_ch          slave stream, two 32-bit coefficients per beat
//   out_ch         master stream, eight pixels per beat, t_strb=t_keep=mask
// Optional macro STREAM_IDCT_PIXEL_ROUND_EN selects round-half-up descale.
module stream_idct_pixel_pack
  import stream_idct_pkg::*;
#(
  parameter int COEF_WIDTH  = 32,
  parameter int DESCALE     = DEFAULT_DESCALE,
  parameter int LEVEL_SHIFT = DEFAULT_LEVEL_SHIFT
) (
  input  logic                aclk,
  input  logic                aresetn,
  nasti_stream_channel.slave  in_ch,
  nasti_stream_channel.master out_ch
);

  localparam int DW = PIXELS_PER_BEAT * PIXEL_WIDTH;
  localparam int PW = COEFS_PER_BEAT * PIXEL_WIDTH;

  logic [PIXEL_WIDTH-1:0]     pix0;
  logic [PIXEL_WIDTH-1:0]     pix1;
  logic [DW-1:0]              acc;
  logic [DW-1:0]              acc_next;
  logic [PIXELS_PER_BEAT-1:0] mask;
  logic [PIXELS_PER_BEAT-1:0] mask_next;
  beat_idx_t                  idx;
  logic                       out_valid;
  logic [DW-1:0]              out_data;
  logic [PIXELS_PER_BEAT-1:0] out_strb;
  logic                       out_last;
  logic                       in_ready;
  logic                       accept;
  logic                       flush;

  idct_pixel_sat #(
    .COEF_WIDTH (COEF_WIDTH),
    .DESCALE    (DESCALE),
    .LEVEL_SHIFT(LEVEL_SHIFT)
  ) u_sat0 (
    .coef (in_ch.t_data[COEF_WIDTH-1:0]),
    .pixel(pix0)
  );

  idct_pixel_sat #(
    .COEF_WIDTH (COEF_WIDTH),
    .DESCALE    (DESCALE),
    .LEVEL_SHIFT(LEVEL_SHIFT)
  ) u_sat1 (
    .coef (in_ch.t_data[COEF_SLOT_WIDTH +: COEF_WIDTH]),
    .pixel(pix1)
  );

  // The output register is the only buffer: input is accepted whenever it
  // is empty or is being emptied on this edge.
  assign in_ready = !out_valid || out_ch.t_ready;
  assign accept   = in_ch.t_valid && in_ready;
  assign flush    = accept && ((idx == 2'd3) || in_ch.t_last);

  always_comb begin
    acc_next = acc;
    acc_next[idx*PW +: PW] = {pix1, pix0};
    mask_next = mask | pair_mask(idx);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc       <= '0;
      mask      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_strb  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ch.t_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (flush) begin
          // Overrides the clear above when a new beat replaces the old one.
          out_valid <= 1'b1;
          out_data  <= acc_next;
          out_strb  <= mask_next;
          out_last  <= in_ch.t_last;
          acc       <= '0;
          mask      <= '0;
          idx       <= '0;
        end else begin
          acc  <= acc_next;
          mask <= mask_next;
          idx  <= idx + 2'd1;
        end
      end
    end
  end

  assign in_ch.t_ready  = in_ready;
  assign out_ch.t_valid = out_valid;
  assign out_ch.t_data  = out_data;
  assign out_ch.t_strb  = out_strb;
  assign out_ch.t_keep  = out_strb;
  assign out_ch.t_last  = out_last;
  assign out_ch.t_id    = '0;
  assign out_ch.t_dest  = '0;
  assign out_ch.t_user  = '0;

endmodule

// File: tb/tb_stream_idct_pixel_pack.sv
module tb_stream_idct_pixel_pack;
  import stream_idct_pkg::*;

  typedef struct {
    logic [31:0] c0;
    logic [31:0] c1;
    logic [7:0]  p0;
    logic [7:0]  p1;
  } vec_t;

`ifdef STREAM_IDCT_PIXEL_ROUND_EN
  localparam logic [7:0] P_POS4  = 8'd129;
  localparam logic [7:0] P_POS7  = 8'd129;
  localparam logic [7:0] P_NEG1  = 8'd128;
`else
  localparam logic [7:0] P_POS4  = 8'd128;
  localparam logic [7:0] P_POS7  = 8'd128;
  localparam logic [7:0] P_NEG1  = 8'd127;
`endif
  localparam int STALL_LIMIT = 200;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  nasti_stream_channel in_if ();
  nasti_stream_channel out_if ();

  stream_idct_pixel_pack #(
    .COEF_WIDTH (32),
    .DESCALE    (3),
    .LEVEL_SHIFT(128)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .in_ch  (in_if),
    .out_ch (out_if)
  );

  // ---------------- scoreboard state ----------------
  int checks       = 0;
  int failures     = 0;
  int stall_cycles = 0;
  int rx_count     = 0;
  logic rand_ready = 1'b0;
  logic [72:0] exp_q[$];
  logic        held_valid = 1'b0;
  logic [72:0] held_beat;
  logic [72:0] mon_cur;
  logic [72:0] mon_exp;
  vec_t vecs[8];

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] coef_for(input logic [7:0] p);
    return 32'((int'(p) - 128) * 8);
  endfunction

  function automatic logic [7:0] pat(input int seed, input int i, input int j);
    return 8'((seed + (i * 2 + j) * 37) & 255);
  endfunction

  task automatic push_exp(input logic [63:0] d, input logic [7:0] s, input logic last);
    exp_q.push_back({last, s, d});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] c0, input logic [31:0] c1, input logic last);
    int   waits = 0;
    logic hs    = 1'b0;
    in_if.t_valid = 1'b1;
    in_if.t_data  = {c1, c0};
    in_if.t_last  = last;
    while (!hs && waits < STALL_LIMIT) begin
      @(negedge aclk);
      hs = in_if.t_ready;
      @(posedge aclk);
      #1;
      if (!hs) waits++;
    end
    stall_cycles += waits;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no ready after %0d cycles expected ready", waits);
    end
    in_if.t_valid = 1'b0;
    in_if.t_last  = 1'b0;
  endtask

  task automatic run_block(input int seed, input int n);
    logic [63:0] d = '0;
    logic [7:0]  s = '0;
    for (int i = 0; i < n; i++) begin
      d[(i % 4) * 16 +: 16] = {pat(seed, i, 1), pat(seed, i, 0)};
      s[(i % 4) * 2 +: 2]   = 2'b11;
      if ((i % 4) == 3 || i == n - 1) begin
        push_exp(d, s, i == n - 1);
        d = '0;
        s = '0;
      end
    end
    for (int i = 0; i < n; i++) begin
      send_beat(coef_for(pat(seed, i, 0)), coef_for(pat(seed, i, 1)), i == n - 1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_if.t_valid) && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_if.t_valid) begin
      failures++;
      $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_state();
    @(negedge aclk);
    check("rst_out_valid", 73'(out_if.t_valid), 73'(0));
    check("rst_out_data",  73'(out_if.t_data),  73'(0));
    check("rst_out_strb",  73'(out_if.t_strb),  73'(0));
    check("rst_out_last",  73'(out_if.t_last),  73'(0));
    check("rst_in_ready",  73'(in_if.t_ready),  73'(1));
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge aclk);
    aresetn = 1'b0;
    // Beats offered during reset must be ignored.
    in_if.t_valid = 1'b1;
    in_if.t_data  = {coef_for(8'd200), coef_for(8'd201)};
    in_if.t_last  = 1'b1;
    for (int i = 0; i < cycles; i++) check_reset_state();
    in_if.t_valid = 1'b0;
    in_if.t_last  = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  // ---------------- output ready driver ----------------
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rand_ready) out_if.t_ready = ($urandom_range(0, 99) < 30);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        held_valid = 1'b0;
      end else begin
        mon_cur = {out_if.t_last, out_if.t_strb, out_if.t_data};
        if (held_valid) begin
          check("stall_valid", 73'(out_if.t_valid), 73'(1));
          check("stall_hold", mon_cur, held_beat);
        end
        if (out_if.t_valid && out_if.t_ready) begin
          held_valid = 1'b0;
          rx_count++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got %h expected none", mon_cur);
          end else begin
            mon_exp = exp_q.pop_front();
            check("out_beat", mon_cur, mon_exp);
            check("out_keep", 73'(out_if.t_keep), 73'(mon_exp[71:64]));
            check("out_sideband", 73'({out_if.t_id, out_if.t_dest, out_if.t_user}), 73'(0));
          end
        end else if (out_if.t_valid) begin
          held_valid = 1'b1;
          held_beat  = mon_cur;
        end else begin
          held_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int rx0;
    in_if.t_valid = 1'b0;
    in_if.t_data  = '0;
    in_if.t_strb  = '0;
    in_if.t_keep  = '0;
    in_if.t_last  = 1'b0;
    in_if.t_id    = '0;
    in_if.t_dest  = '0;
    in_if.t_user  = '0;
    out_if.t_ready = 1'b1;

    vecs[0] = '{32'd0,         32'd0,         8'd128, 8'd128};
    vecs[1] = '{32'd1100,      -32'sd1100,    8'd255, 8'd0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h8000_0000, 8'd255, 8'd0};
    vecs[3] = '{32'd4,         -32'sd5,       P_POS4, 8'd127};
    vecs[4] = '{32'd8,         -32'sd8,       8'd129, 8'd127};
    vecs[5] = '{32'd1016,      -32'sd1024,    8'd255, 8'd0};
    vecs[6] = '{32'd1024,      -32'sd1032,    8'd255, 8'd0};
    vecs[7] = '{32'd7,         32'hFFFF_FFFF, P_POS7, P_NEG1};

    apply_reset(3);

    // Single-beat blocks: conversion, saturation, rounding, one-cycle latency.
    for (int v = 0; v < 8; v++) begin
      push_exp({48'h0, vecs[v].p1, vecs[v].p0}, 8'h03, 1'b1);
      send_beat(vecs[v].c0, vecs[v].c1, 1'b1);
      check("latency_valid", 73'(out_if.t_valid), 73'(1));
    end
    wait_drain();

    // Full 8x8 block of zeros at full rate.
    rx0 = rx_count;
    stall_cycles = 0;
    for (int b = 0; b < 8; b++) push_exp(64'h8080_8080_8080_8080, 8'hFF, b == 7);
    for (int i = 0; i < 32; i++) send_beat(32'd0, 32'd0, i == 31);
    check("zero_block_stalls", 73'(stall_cycles), 73'(0));
    wait_drain();
    check("zero_block_beats", 73'(rx_count - rx0), 73'(8));

    // Short block: three beats, flushed by t_last.
    push_exp(64'h0000_3C32_281E_140A, 8'h3F, 1'b1);
    send_beat(coef_for(8'd10), coef_for(8'd20), 1'b0);
    send_beat(coef_for(8'd30), coef_for(8'd40), 1'b0);
    send_beat(coef_for(8'd50), coef_for(8'd60), 1'b1);
    wait_drain();

    // Same block without and with 30% output backpressure.
    rx0 = rx_count;
    run_block(5, 32);
    wait_drain();
    rand_ready = 1'b1;
    run_block(5, 32);
    wait_drain();
    rand_ready = 1'b0;
    out_if.t_ready = 1'b1;
    @(posedge aclk);
    #1;
    check("stall_run_beats", 73'(rx_count - rx0), 73'(16));

    // Reset in the middle of a block discards the partial data.
    send_beat(coef_for(8'd77), coef_for(8'd88), 1'b0);
    send_beat(coef_for(8'd99), coef_for(8'd11), 1'b0);
    apply_reset(2);
    rx0 = rx_count;
    run_block(60, 32);
    wait_drain();
    check("post_reset_beats", 73'(rx_count - rx0), 73'(8));
    push_exp({48'h0, 8'd42, 8'd24}, 8'h03, 1'b1);
    send_beat(coef_for(8'd24), coef_for(8'd42), 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
